id_ex_stage: RTL

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It sits between decode and execute. It captures decoded operands, register indices and control bits from ID, and presents them to the EX stage, including the forwarding unit's rs/rt comparators. When a load in EX targets a register read by the instruction in ID, it inserts a one-cycle bubble and stalls PC and IF/ID. It also handles branch flushes and global halt.

---
 rtl/id_ex_stage.sv | 81 ++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
// Squashes to a zeroed bubble on flush or load-use; holds everything on halt.
module id_ex_stage #(
  parameter int N_BITS_REG  = 5,
  parameter int N_BITS_DATA = 32,
  parameter int N_CTRL      = 8,
  parameter int N_BITS_CNT  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid_ID,
  input  logic [N_BITS_REG-1:0]  i_rs_ID,
  input  logic [N_BITS_REG-1:0]  i_rt_ID,
  input  logic [N_BITS_REG-1:0]  i_rd_ID,
  input  logic [N_BITS_DATA-1:0] i_data_a_ID,
  input  logic [N_BITS_DATA-1:0] i_data_b_ID,
  input  logic [N_BITS_DATA-1:0] i_imm_ID,
  input  logic [N_CTRL-1:0]      i_ctrl_ID,
  input  logic                   i_flush,
  input  logic                   i_halt,
  output logic                   o_valid_EX,
  output logic [N_BITS_REG-1:0]  o_rs_EX,
  output logic [N_BITS_REG-1:0]  o_rt_EX,
  output logic [N_BITS_REG-1:0]  o_rd_EX,
  output logic [N_BITS_DATA-1:0] o_data_a_EX,
  output logic [N_BITS_DATA-1:0] o_data_b_EX,
  output logic [N_BITS_DATA-1:0] o_imm_EX,
  output logic [N_CTRL-1:0]      o_ctrl_EX,
  output logic                   o_stall,
  output logic [N_BITS_CNT-1:0]  o_bubble_cnt
);

  logic load_use;
  logic bubble;

  // Only registered EX state and ID indices feed the stall path, never data.
  always_comb begin
    load_use = o_valid_EX & o_ctrl_EX[1] & (o_rt_EX != '0) & i_valid_ID &
               ((o_rt_EX == i_rs_ID) | (o_rt_EX == i_rt_ID));
    o_stall  = ~i_halt & ~i_flush & load_use;
    bubble   = ~i_halt & (i_flush | load_use);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_EX   <= 1'b0;
      o_rs_EX      <= '0;
      o_rt_EX      <= '0;
      o_rd_EX      <= '0;
      o_data_a_EX  <= '0;
      o_data_b_EX  <= '0;
      o_imm_EX     <= '0;
      o_ctrl_EX    <= '0;
      o_bubble_cnt <= '0;
    end else if (!i_halt) begin
      if (bubble) begin
        o_valid_EX  <= 1'b0;
        o_rs_EX     <= '0;
        o_rt_EX     <= '0;
        o_rd_EX     <= '0;
        o_data_a_EX <= '0;
        o_data_b_EX <= '0;
        o_imm_EX    <= '0;
        o_ctrl_EX   <= '0;
      end else begin
        o_valid_EX  <= i_valid_ID;
        o_rs_EX     <= i_rs_ID;
        o_rt_EX     <= i_rt_ID;
        o_rd_EX     <= i_rd_ID;
        o_data_a_EX <= i_data_a_ID;
        o_data_b_EX <= i_data_b_ID;
        o_imm_EX    <= i_imm_ID;
        o_ctrl_EX   <= i_ctrl_ID;
      end
      // Count only true load-use bubbles, not flush bubbles.
      if (o_stall && (o_bubble_cnt != '1))
        o_bubble_cnt <= o_bubble_cnt + {{(N_BITS_CNT-1){1'b0}}, 1'b1};
    end
  end

endmodule
